// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage access engine: access sizes, exception
// codes, address map and FSM states, plus bus lane helpers.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] DM_TOP_DEF  = 32'h0000_2FFF;
    localparam logic [31:0] IO_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] IO_TOP_DEF  = 32'h0000_7F1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: byte_enables = 4'b0001 << lane;
            SZ_HALF: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    // Store data is copied onto every lane so the bridge can pick any byte lane
    function automatic logic [31:0] lane_replicate(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: lane_replicate = {4{d[7:0]}};
            SZ_HALF: lane_replicate = {2{d[15:0]}};
            default: lane_replicate = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// System-bridge bus: single outstanding request, one-cycle ack pulse.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_unit_load_extender.sv
// Lane select and zero/sign extension of captured load data.
module load_extender
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane, then widen it to 32 bits
    always_comb begin
        byte_s = rdata[{lane, 3'b000} +: 8];
        half_s = rdata[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: data = {{16{sign_ext & half_s[15]}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store engine: legality check, single bus transaction with
// timeout, M/W stall and extended load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter logic [31:0] DM_TOP  = DM_TOP_DEF,
    parameter logic [31:0] IO_BASE = IO_BASE_DEF,
    parameter logic [31:0] IO_TOP  = IO_TOP_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_M,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [1:0]               size,
    input  logic                     load_signed,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    mem_access_unit_if.master        bus,
    output logic                     mem_busy,
    output logic [31:0]              data_M,
    output logic                     exc_valid,
    output logic [4:0]               exc_code
);

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic [1:0]  lat_size_q, lat_size_d;
    logic        lat_sign_q, lat_sign_d;
    logic [1:0]  lat_lane_q, lat_lane_d;
    logic        lat_we_q, lat_we_d;

    logic [1:0]  size_eff_s;
    logic        access_s;
    logic        misaligned_s;
    logic        in_dm_s;
    logic        in_io_s;
    logic        illegal_s;
    logic [7:0]  cnt_inc_s;
    logic [31:0] ext_data_s;

    load_extender u_load_extender (
        .rdata    (rdata_q),
        .size     (lat_size_q),
        .lane     (lat_lane_q),
        .sign_ext (lat_sign_q),
        .data     (ext_data_s)
    );

    // Legality of the request currently presented by the M stage
    always_comb begin
        size_eff_s = (size == SZ_RSVD) ? SZ_WORD : size;
        access_s   = valid_M & (mem_read | mem_write);
        case (size_eff_s)
            SZ_HALF: misaligned_s = addr[0];
            SZ_WORD: misaligned_s = (addr[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        in_dm_s   = (addr <= DM_TOP);
        in_io_s   = (addr >= IO_BASE) && (addr <= IO_TOP);
        illegal_s = misaligned_s | ~(in_dm_s | in_io_s) | (in_io_s & (size_eff_s != SZ_WORD));
        cnt_inc_s = cnt_q + 8'd1;
    end

    // Next-state, bus register updates and M-stage outputs
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        lat_size_d  = lat_size_q;
        lat_sign_d  = lat_sign_q;
        lat_lane_d  = lat_lane_q;
        lat_we_d    = lat_we_q;
        mem_busy    = 1'b0;
        exc_valid   = 1'b0;
        exc_code    = EXC_NONE;
        data_M      = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (access_s && illegal_s) begin
                    exc_valid = 1'b1;
                    exc_code  = mem_write ? EXC_ADES : EXC_ADEL;
                end else if (access_s) begin
                    mem_busy    = 1'b1;
                    state_d     = ST_WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = byte_enables(size_eff_s, addr[1:0]);
                    bus_wdata_d = lane_replicate(size_eff_s, wdata);
                    cnt_d       = 8'd0;
                    tmo_d       = 1'b0;
                    lat_size_d  = size_eff_s;
                    lat_sign_d  = load_signed;
                    lat_lane_d  = addr[1:0];
                    lat_we_d    = mem_write;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                mem_busy = 1'b1;
                // An ack on the final allowed cycle still completes normally
                if (bus.bus_ack) begin
                    rdata_d   = bus.bus_rdata;
                    cnt_d     = 8'd0;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_inc_s == 8'(TIMEOUT)) begin
                    cnt_d     = 8'd0;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    tmo_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (tmo_q) begin
                    exc_valid = 1'b1;
                    exc_code  = lat_we_q ? EXC_ADES : EXC_ADEL;
                end else if (!lat_we_q) begin
                    data_M = ext_data_s;
                end else begin
                    data_M = 32'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus registers; reset clears any pending request at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            cnt_q       <= 8'd0;
            tmo_q       <= 1'b0;
            lat_size_q  <= SZ_BYTE;
            lat_sign_q  <= 1'b0;
            lat_lane_q  <= 2'b00;
            lat_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            lat_size_q  <= lat_size_d;
            lat_sign_q  <= lat_sign_d;
            lat_lane_q  <= lat_lane_d;
            lat_we_q    <= lat_we_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan items, address-map
// boundaries, randomized back-to-back accesses and reset behaviour.
module tb_mem_access_unit;

    localparam int unsigned TMO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_M;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_busy;
    logic [31:0] data_M;
    logic        exc_valid;
    logic [4:0]  exc_code;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_M     (valid_M),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .size        (size),
        .load_signed (load_signed),
        .addr        (addr),
        .wdata       (wdata),
        .bus         (bus),
        .mem_busy    (mem_busy),
        .data_M      (data_M),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic exp_legal(input logic [1:0] sz, input logic [31:0] a);
        int   n;
        logic in_dm, in_io;
        n     = nbytes(sz);
        in_dm = (a <= 32'h0000_2FFF);
        in_io = (a >= 32'h0000_7F00) && (a <= 32'h0000_7F1B);
        if ((a % n) != 0) return 1'b0;
        return in_dm || (in_io && n == 4);
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(sz)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        int n;
        n = nbytes(sz);
        if (n == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (n == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] sz,
                                             input logic sgn, input logic [31:0] a);
        int          n;
        logic [63:0] mask;
        logic [31:0] v;
        n    = nbytes(sz);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = (rd >> (8 * (a % 4))) & mask[31:0];
        if (sgn && n < 4 && v[8 * n - 1]) v = v | ~mask[31:0];
        return v;
    endfunction

    // One complete M-stage access; ack_at = WAIT cycle of the ack (0 = never)
    task automatic run_access(input string nm, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic sgn, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdv, input int ack_at);
        logic        legal, tmo;
        logic [4:0]  ecode;
        logic [31:0] exp_d;
        int          busy_cnt, exp_busy;
        legal = exp_legal(sz, a);
        tmo   = (ack_at == 0) || (ack_at > int'(TMO));
        ecode = wr ? 5'd5 : 5'd4;
        valid_M = 1'b1; mem_read = rd; mem_write = wr; size = sz; load_signed = sgn;
        addr = a; wdata = wd; bus.bus_ack = 1'b0; bus.bus_rdata = $urandom;
        #1;
        if (!(rd | wr)) begin
            n_checks++;
            if (mem_busy !== 1'b0 || exc_valid !== 1'b0) begin
                n_fail++; $display("FAIL %s noaccess busy=%b exc=%b required 0/0", nm, mem_busy, exc_valid);
            end
            tick();
            n_checks++;
            if (bus.bus_req !== 1'b0) begin
                n_fail++; $display("FAIL %s noaccess bus_req=%b required 0", nm, bus.bus_req);
            end
            return;
        end
        if (!legal) begin
            n_checks++;
            if (exc_valid !== 1'b1 || exc_code !== ecode || mem_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s illegal exc=%b code=%0d busy=%b required 1/%0d/0", nm, exc_valid, exc_code, mem_busy, ecode);
            end
            tick();
            n_checks++;
            if (bus.bus_req !== 1'b0) begin
                n_fail++; $display("FAIL %s illegal bus_req=%b required 0", nm, bus.bus_req);
            end
            return;
        end
        n_checks++;
        if (mem_busy !== 1'b1 || exc_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s idle busy=%b exc=%b required 1/0", nm, mem_busy, exc_valid);
        end
        tick();
        busy_cnt = 1;
        n_checks++;
        if (bus.bus_req !== 1'b1 || bus.bus_we !== wr || bus.bus_addr !== (a & 32'hFFFF_FFFC)
            || bus.bus_be !== exp_be(sz, a)) begin
            n_fail++;
            $display("FAIL %s bus req=%b we=%b addr=%h be=%b required 1/%b/%h/%b", nm, bus.bus_req,
                     bus.bus_we, bus.bus_addr, bus.bus_be, wr, a & 32'hFFFF_FFFC, exp_be(sz, a));
        end
        if (wr) begin
            n_checks++;
            if (bus.bus_wdata !== exp_wdata(sz, wd)) begin
                n_fail++; $display("FAIL %s wdata=%h required %h", nm, bus.bus_wdata, exp_wdata(sz, wd));
            end
        end
        for (int k = 1; k <= int'(TMO) + 4; k++) begin
            bus.bus_ack   = (k == ack_at);
            bus.bus_rdata = (k == ack_at) ? rdv : $urandom;
            #1;
            if (mem_busy !== 1'b1) break;
            busy_cnt++;
            tick();
        end
        bus.bus_ack = 1'b0;
        exp_busy = 1 + (tmo ? int'(TMO) : ack_at);
        n_checks++;
        if (busy_cnt != exp_busy) begin
            n_fail++; $display("FAIL %s busy_cycles=%0d required %0d", nm, busy_cnt, exp_busy);
        end
        exp_d = (tmo || wr) ? 32'd0 : exp_load(rdv, sz, sgn, a);
        n_checks++;
        if (bus.bus_req !== 1'b0 || bus.bus_we !== 1'b0 || exc_valid !== tmo
            || exc_code !== (tmo ? ecode : 5'd0) || data_M !== exp_d) begin
            n_fail++;
            $display("FAIL %s done req=%b we=%b exc=%b code=%0d data=%h required 0/0/%b/%0d/%h", nm,
                     bus.bus_req, bus.bus_we, exc_valid, exc_code, data_M, tmo, tmo ? ecode : 5'd0, exp_d);
        end
        tick();
    endtask

    task automatic go_idle(input int cycles);
        valid_M = 1'b0; bus.bus_ack = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            n_checks++;
            if (mem_busy !== 1'b0 || exc_valid !== 1'b0 || data_M !== 32'd0) begin
                n_fail++; $display("FAIL idle busy=%b exc=%b data=%h required 0/0/0", mem_busy, exc_valid, data_M);
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; valid_M = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
        load_signed = 1'b0; addr = 32'd0; wdata = 32'd0; bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.bus_req !== 1'b0 || bus.bus_we !== 1'b0 || bus.bus_addr !== 32'd0 || bus.bus_be !== 4'd0
            || bus.bus_wdata !== 32'd0 || mem_busy !== 1'b0 || exc_valid !== 1'b0 || data_M !== 32'd0) begin
            n_fail++;
            $display("FAIL reset req=%b we=%b addr=%h be=%b wd=%h busy=%b exc=%b data=%h required all 0",
                     bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata, mem_busy, exc_valid, data_M);
        end
        @(negedge clk) reset = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_access("word_store", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'd0, 1);
        run_access("byte_ld_s", 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'h80FF_FF7F, 1);
        run_access("byte_ld_u", 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'h80FF_FF7F, 2);
        run_access("half_misal", 1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 32'd0, 1);
        run_access("io_word_ld", 1'b1, 1'b0, 2'b10, 1'b0, 32'h7F04, 32'd0, 32'hCAFE_F00D, 5);
        run_access("io_byte_st", 1'b0, 1'b1, 2'b00, 1'b0, 32'h7F04, 32'hAB, 32'd0, 1);
        run_access("timeout_ld", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 32'd0, 0);
        run_access("timeout_st", 1'b0, 1'b1, 2'b01, 1'b0, 32'h2FFE, 32'h5555, 32'd0, 0);
        run_access("ack_at_tmo", 1'b1, 1'b0, 2'b01, 1'b1, 32'h2FFE, 32'd0, 32'h9234_0000, int'(TMO));
        run_access("rw_is_st", 1'b1, 1'b1, 2'b11, 1'b0, 32'h7F18, 32'h0BAD_BEEF, 32'd0, 3);
        run_access("dm_top+1", 1'b1, 1'b0, 2'b00, 1'b0, 32'h3000, 32'd0, 32'd0, 1);
        run_access("io_top+1", 1'b0, 1'b1, 2'b10, 1'b0, 32'h7F1C, 32'd0, 32'd0, 1);
        run_access("io_half", 1'b1, 1'b0, 2'b01, 1'b0, 32'h7F00, 32'd0, 32'd0, 1);
        run_access("dm_top_b", 1'b1, 1'b0, 2'b00, 1'b1, 32'h2FFF, 32'd0, 32'h7F00_0000, 1);
        go_idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, rdv;
        logic [1:0]  sz, rw, pick;
        int          ack;
        for (int i = 0; i < 40; i++) begin
            pick = 2'($urandom_range(0, 3));
            case (pick)
                2'd0: a = $urandom_range(0, 32'h2FFF);
                2'd1: a = $urandom_range(32'h7F00, 32'h7F1B);
                2'd2: a = (($urandom & 1) != 0) ? $urandom_range(32'h3000, 32'h3003) : $urandom_range(32'h7F1C, 32'h7F1F);
                default: a = $urandom;
            endcase
            sz   = 2'($urandom_range(0, 3));
            rw   = 2'($urandom_range(0, 3));
            rdv  = $urandom;
            ack  = (($urandom % 8) == 0) ? $urandom_range(0, int'(TMO) + 1) : $urandom_range(1, 4);
            run_access("rand", rw[1], rw[0], sz, 1'($urandom & 1), a, $urandom, rdv, ack);
        end
        go_idle(2);
    endtask

    task automatic test_idle_quiet();
        for (int i = 0; i < 6; i++) begin
            mem_read = 1'($urandom & 1); mem_write = 1'($urandom & 1); addr = $urandom;
            size = 2'($urandom_range(0, 3)); bus.bus_ack = 1'($urandom & 1);
            valid_M = 1'b0;
            #1;
            n_checks++;
            if (mem_busy !== 1'b0 || exc_valid !== 1'b0 || bus.bus_req !== 1'b0) begin
                n_fail++; $display("FAIL quiet busy=%b exc=%b req=%b required 0/0/0", mem_busy, exc_valid, bus.bus_req);
            end
            tick();
        end
        bus.bus_ack = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        valid_M = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; load_signed = 1'b0;
        addr = 32'h20; bus.bus_ack = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.bus_req !== 1'b1 || mem_busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait pre req=%b busy=%b required 1/1", bus.bus_req, mem_busy);
        end
        #2;
        reset = 1'b0; valid_M = 1'b0;
        #1;
        n_checks++;
        if (bus.bus_req !== 1'b0 || mem_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait drop req=%b busy=%b required 0/0", bus.bus_req, mem_busy);
        end
        @(negedge clk) reset = 1'b1;
        tick();
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (mem_busy !== 1'b0 || exc_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait stray_ack busy=%b exc=%b required 0/0", mem_busy, exc_valid);
        end
        tick();
        bus.bus_ack = 1'b0;
        #1;
        n_checks++;
        if (bus.bus_req !== 1'b0 || mem_busy !== 1'b0 || exc_valid !== 1'b0 || data_M !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_wait after req=%b busy=%b exc=%b data=%h required 0/0/0/0", bus.bus_req, mem_busy, exc_valid, data_M);
        end
        tick();
        run_access("post_rst", 1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 32'h8001_0002, 2);
        go_idle(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_idle_quiet();
        test_back_to_back();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
